// File: rtl/btn_sw_conditioner.sv
// -----------------------------------------------------------------------------
// btn_sw_conditioner
//
// Input conditioning for the mode/LED demo block. The four push-buttons and
// two slide switches arrive as asynchronous board pins. Each pin is brought
// into the clk_125 domain, debounced, and presented as a clean level. Buttons
// also produce a one-cycle press pulse on every accepted rising edge. Those
// pulses are priority-encoded (btn3 > btn2 > btn1 > btn0) into a latched mode
// request, so downstream logic sees exactly one request per physical press.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive synchronised cycles a new level
//                     must hold before it is accepted (>= 1)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk_125         in   1  system clock, the only clock
//   rst             in   1  synchronous active-high reset
//   btn_raw         in   4  asynchronous push-button pins
//   sw_raw          in   2  asynchronous slide-switch pins
//   btn_clean       out  4  debounced button levels
//   btn_press       out  4  one-cycle pulse per debounced button rising edge
//   sw_clean        out  2  debounced switch levels
//   mode_req_valid  out  1  one-cycle pulse when a new request is latched
//   mode_req        out  2  last requested mode, held between requests
//
// Latency: a raw level first sampled at edge E is visible on the clean
// outputs after edge E+1+DEBOUNCE_CYCLES. The press pulse shares that cycle,
// and mode_req_valid follows one edge later.
// -----------------------------------------------------------------------------
module btn_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int CNT_W           = 21
) (
    input  logic       clk_125,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic [1:0] sw_raw,
    output logic [3:0] btn_clean,
    output logic [3:0] btn_press,
    output logic [1:0] sw_clean,
    output logic       mode_req_valid,
    output logic [1:0] mode_req
);

    // Buttons occupy bits [3:0], switches bits [5:4] of the shared datapath.
    localparam int N_IN = 6;

    // Terminal count: the cycle on which the counter sits here while s2
    // still disagrees with the stable level is the acceptance cycle.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Priority encoder for the press vector: the highest set index wins.
    // When nothing is set the result is unused, so 0 is a safe filler.
    function automatic logic [1:0] prio_enc(input logic [3:0] p);
        logic [1:0] idx;
        if (p[3]) begin
            idx = 2'd3;
        end else if (p[2]) begin
            idx = 2'd2;
        end else if (p[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    logic [N_IN-1:0]  raw_in;

    logic [N_IN-1:0]  sync_s1_q, sync_s1_d;
    logic [N_IN-1:0]  sync_s2_q, sync_s2_d;
    logic [N_IN-1:0]  stable_q,  stable_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic [3:0]       btn_press_q, btn_press_d;
    logic             mode_req_valid_q, mode_req_valid_d;
    logic [1:0]       mode_req_q, mode_req_d;

    assign raw_in = {sw_raw, btn_raw};

    // Two-flop synchroniser chain; only s2 feeds the debouncers.
    always_comb begin
        sync_s1_d = raw_in;
        sync_s2_d = sync_s1_q;
    end

    // Per-bit debounce: count consecutive cycles of disagreement with the
    // accepted level, and accept the new level once the run is long enough.
    // Any cycle of agreement clears the run, which rejects short glitches.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_MAX) begin
                stable_d[i] = sync_s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
            end
        end
    end

    // Press pulse is computed from the next stable value, so it is high in
    // exactly the cycle where btn_clean first reads 1 (rising edges only).
    always_comb begin
        btn_press_d = stable_d[3:0] & ~stable_q[3:0];
    end

    // Mode request: latch the highest pressed index one cycle after the
    // press pulse, otherwise hold the previous request.
    always_comb begin
        if (|btn_press_q) begin
            mode_req_valid_d = 1'b1;
            mode_req_d       = prio_enc(btn_press_q);
        end else begin
            mode_req_valid_d = 1'b0;
            mode_req_d       = mode_req_q;
        end
    end

    // State registers; reset overrides everything, including a debounce run.
    always_ff @(posedge clk_125) begin
        if (rst) begin
            sync_s1_q        <= '0;
            sync_s2_q        <= '0;
            stable_q         <= '0;
            btn_press_q      <= '0;
            mode_req_valid_q <= 1'b0;
            mode_req_q       <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_s1_q        <= sync_s1_d;
            sync_s2_q        <= sync_s2_d;
            stable_q         <= stable_d;
            btn_press_q      <= btn_press_d;
            mode_req_valid_q <= mode_req_valid_d;
            mode_req_q       <= mode_req_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_clean      = stable_q[3:0];
    assign sw_clean       = stable_q[5:4];
    assign btn_press      = btn_press_q;
    assign mode_req_valid = mode_req_valid_q;
    assign mode_req       = mode_req_q;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Bench for btn_sw_conditioner with DEBOUNCE_CYCLES=4. A sliding-window
// reference model (a level is accepted once the last D synchronised samples
// all disagree with the accepted level) is compared against the DUT on every
// cycle after the first reset; directed scenarios add literal expectations.
module tb_btn_sw_conditioner;

    localparam int D = 4;

    logic       clk_125 = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [1:0] sw_raw;
    logic [3:0] btn_clean;
    logic [3:0] btn_press;
    logic [1:0] sw_clean;
    logic       mode_req_valid;
    logic [1:0] mode_req;

    int checks = 0;
    int errors = 0;

    btn_sw_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk_125       (clk_125),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .sw_raw        (sw_raw),
        .btn_clean     (btn_clean),
        .btn_press     (btn_press),
        .sw_clean      (sw_clean),
        .mode_req_valid(mode_req_valid),
        .mode_req      (mode_req)
    );

    always #4 clk_125 = ~clk_125;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] m_s1, m_s2, m_stable, nst;
    bit         m_h [6][D];   // last D synchronised samples per bit, [0] newest
    int         m_n [6];      // samples collected since reset / last acceptance
    logic [3:0] m_press;
    logic       m_valid;
    logic [1:0] m_req;
    bit         m_ok = 1'b0;
    bit         all_diff;

    always @(posedge clk_125) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_press = '0; m_valid = 1'b0; m_req = '0;
            for (int b = 0; b < 6; b++) m_n[b] = 0;
            m_ok = 1'b1;
        end else begin
            if (m_press != 4'b0000) begin
                m_valid = 1'b1;
                for (int i = 0; i < 4; i++) if (m_press[i]) m_req = 2'(i);
            end else begin
                m_valid = 1'b0;
            end
            nst = m_stable;
            for (int b = 0; b < 6; b++) begin
                for (int k = D - 1; k > 0; k--) m_h[b][k] = m_h[b][k-1];
                m_h[b][0] = m_s2[b];
                if (m_n[b] < D) m_n[b]++;
                all_diff = (m_n[b] == D);
                for (int k = 0; k < D; k++) if (m_h[b][k] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) begin
                    nst[b] = ~m_stable[b];
                    m_n[b] = 0;
                end
            end
            m_press  = nst[3:0] & ~m_stable[3:0];
            m_stable = nst;
            m_s2     = m_s1;
            m_s1     = {sw_raw, btn_raw};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_125) begin
        if (m_ok) begin
            chk("model_btn_clean", {4'b0000, btn_clean}, {4'b0000, m_stable[3:0]});
            chk("model_sw_clean",  {6'b000000, sw_clean}, {6'b000000, m_stable[5:4]});
            chk("model_btn_press", {4'b0000, btn_press}, {4'b0000, m_press});
            chk("model_valid",     {7'b0000000, mode_req_valid}, {7'b0000000, m_valid});
            chk("model_mode_req",  {6'b000000, mode_req}, {6'b000000, m_req});
        end
    end

    // ---------------- stimulus ----------------
    int press_seen [4];
    int valid_seen;

    task automatic clr_seen();
        for (int i = 0; i < 4; i++) press_seen[i] = 0;
        valid_seen = 0;
    endtask

    // Advance n clock edges, ending at the following negedge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_125);
            @(negedge clk_125);
            for (int i = 0; i < 4; i++) press_seen[i] += int'(btn_press[i]);
            valid_seen += int'(mode_req_valid);
        end
    endtask

    initial begin
        rst = 1'b1; btn_raw = 4'b0000; sw_raw = 2'b00;
        clr_seen();
        @(negedge clk_125);

        // 1. reset state, then buttons pressed while reset is held
        step(3);
        chk("rst_btn_clean", {4'b0000, btn_clean}, 8'h00);
        chk("rst_sw_clean", {6'b000000, sw_clean}, 8'h00);
        chk("rst_valid_req", {5'b00000, mode_req_valid, mode_req}, 8'h00);
        btn_raw = 4'b1111;
        step(8);
        chk("rst_hold_btn_clean", {4'b0000, btn_clean}, 8'h00);
        chk("rst_hold_press", {4'b0000, btn_press}, 8'h00);
        btn_raw = 4'b0000;
        step(2);
        rst = 1'b0;
        step(4);

        // 2. single press of btn1, held 12 cycles, then release
        btn_raw = 4'b0010;
        step(5);
        chk("s2_clean_E4", {4'b0000, btn_clean}, 8'h00);
        step(1);
        chk("s2_clean_E5", {4'b0000, btn_clean}, 8'h02);
        chk("s2_press_E5", {4'b0000, btn_press}, 8'h02);
        step(1);
        chk("s2_press_E6", {4'b0000, btn_press}, 8'h00);
        chk("s2_valid_E6", {7'b0000000, mode_req_valid}, 8'h01);
        chk("s2_req_E6", {6'b000000, mode_req}, 8'h01);
        step(5);
        btn_raw = 4'b0000;
        clr_seen();
        step(10);
        chk("s2_release_press", 8'(press_seen[1]), 8'h00);
        chk("s2_release_clean", {4'b0000, btn_clean}, 8'h00);
        chk("s2_req_held", {6'b000000, mode_req}, 8'h01);

        // 3. short glitch rejected, then bouncing press accepted once
        clr_seen();
        btn_raw = 4'b0100;
        step(3);
        btn_raw = 4'b0000;
        step(10);
        chk("s3_glitch_press", 8'(press_seen[2]), 8'h00);
        chk("s3_glitch_valid", 8'(valid_seen), 8'h00);
        for (int t = 0; t < 6; t++) begin
            btn_raw[2] = ~btn_raw[2];
            step(2);
        end
        btn_raw = 4'b0100;
        step(10);
        chk("s3_bounce_press_count", 8'(press_seen[2]), 8'h01);
        chk("s3_bounce_req", {6'b000000, mode_req}, 8'h02);
        btn_raw = 4'b0000;
        step(8);

        // 4. simultaneous press of 1101
        clr_seen();
        btn_raw = 4'b1101;
        step(6);
        chk("s4_press", {4'b0000, btn_press}, 8'h0d);
        step(1);
        chk("s4_valid", {7'b0000000, mode_req_valid}, 8'h01);
        chk("s4_req", {6'b000000, mode_req}, 8'h03);
        step(6);
        chk("s4_valid_count", 8'(valid_seen), 8'h01);
        btn_raw = 4'b0000;
        step(8);

        // 5. switch only
        clr_seen();
        sw_raw = 2'b10;
        step(5);
        chk("s5_sw_E4", {6'b000000, sw_clean}, 8'h00);
        step(1);
        chk("s5_sw_E5", {6'b000000, sw_clean}, 8'h02);
        step(4);
        chk("s5_valid_count", 8'(valid_seen), 8'h00);
        chk("s5_press_any", 8'(press_seen[0] + press_seen[1] + press_seen[2] + press_seen[3]), 8'h00);
        chk("s5_req_held", {6'b000000, mode_req}, 8'h03);
        sw_raw = 2'b00;
        step(8);

        // 6. button held across a reset pulse
        btn_raw = 4'b0001;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        chk("s6_clean_E4", {4'b0000, btn_clean}, 8'h00);
        step(1);
        chk("s6_clean_E5", {4'b0000, btn_clean}, 8'h01);
        step(1);
        chk("s6_valid", {7'b0000000, mode_req_valid}, 8'h01);
        chk("s6_req", {6'b000000, mode_req}, 8'h00);
        btn_raw = 4'b0000;
        step(8);

        // Randomised phase: random levels, random hold times, rare resets.
        for (int seg = 0; seg < 400; seg++) begin
            btn_raw = 4'($urandom);
            sw_raw  = 2'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                step(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end
            step(int'($urandom_range(1, 10)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
